// File: rtl/sram_arb_pkg.sv
// Shared types and address-decode helpers for the SRAM bank arbiter.
package sram_arb_pkg;

  // Owner field is sized for the largest supported master count (8).
  localparam int OWN_W = 3;

  // One registered response slot per bank.
  typedef struct packed {
    logic             vld;
    logic             we;
    logic             err;
    logic [OWN_W-1:0] owner;
  } rsp_t;

  // Bank-select field: every address bit from bsel_lsb upward. Any value
  // at or above the bank count, including stray high bits, is unmapped.
  function automatic logic [63:0] bank_idx(input logic [63:0] addr, input int bsel_lsb);
    return addr >> bsel_lsb;
  endfunction

  // Byte address to bank word address (caller truncates to BANK_AW).
  function automatic logic [63:0] bank_waddr(input logic [63:0] addr, input int byte_w);
    return addr >> byte_w;
  endfunction

endpackage

// File: rtl/sram_bank_arb_rr_arb.sv
// N-way one-hot arbiter, one instance per bank. Round-robin from an
// internal pointer, or fixed priority (index 0 highest) when RR_EN=0.
module rr_arb #(
  parameter int N     = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_j;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_pick;
  logic          w_found;

  // First requestor found scanning upward from the pointer, wrapping at N-1.
  always_comb begin
    w_pick  = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int i = 0; i < N; i++) begin
      w_j = PW'((int'(r_ptr) + i) % N);
      if (!w_found && i_req[w_j]) begin
        w_found     = 1'b1;
        w_pick[w_j] = 1'b1;
        w_win       = w_j;
      end
    end
  end

  // A busy bank grants nothing, so the pointer holds too.
  assign o_gnt     = i_en ? w_pick : '0;
  assign w_ptr_nxt = (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;

  if (RR_EN) begin : g_rr
    // Pointer moves just past the winner after every grant.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_ptr <= '0;
      else if (|o_gnt) r_ptr <= w_ptr_nxt;
    end
  end else begin : g_fixed
    assign r_ptr = '0;
  end

endmodule

// File: rtl/sram_bank_arb.sv
// N-master x M-bank SRAM arbiter: decode, per-bank arbitration, bank
// command mux, one-cycle registered response path with unmapped flagging.
module sram_bank_arb
  import sram_arb_pkg::*;
#(
  parameter int N_MST    = 4,
  parameter int N_BANK   = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int BANK_AW  = 14,
  parameter int BSEL_LSB = 16,
  parameter bit RR_EN    = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_MST-1:0]                  m_req,
  input  logic [N_MST-1:0]                  m_we,
  input  logic [N_MST-1:0][AW-1:0]          m_addr,
  input  logic [N_MST-1:0][DW/8-1:0]        m_byte,
  input  logic [N_MST-1:0][DW-1:0]          m_wdata,
  output logic [N_MST-1:0]                  m_gnt,
  output logic [N_MST-1:0]                  m_rvalid,
  output logic [N_MST-1:0][DW-1:0]          m_rdata,
  output logic [N_MST-1:0]                  m_err,
  output logic [N_BANK-1:0]                 b_cs,
  output logic [N_BANK-1:0]                 b_we,
  output logic [N_BANK-1:0][BANK_AW-1:0]    b_addr,
  output logic [N_BANK-1:0][DW/8-1:0]       b_byte,
  output logic [N_BANK-1:0][DW-1:0]         b_di,
  input  logic [N_BANK-1:0][DW-1:0]         b_do,
  input  logic [N_BANK-1:0]                 b_busy
);

  localparam int FW = AW - BSEL_LSB;
  localparam int BW = $clog2(DW/8);

  logic [N_MST-1:0][FW-1:0]        w_bidx;
  logic [N_MST-1:0][BANK_AW-1:0]   w_waddr;
  logic [N_MST-1:0]                w_unmap;
  logic [N_BANK-1:0][N_MST-1:0]    w_breq;
  logic [N_BANK-1:0][N_MST-1:0]    w_bgnt;
  logic [N_BANK-1:0][OWN_W-1:0]    w_own;
  rsp_t [N_BANK-1:0]               r_rsp;
  logic [N_MST-1:0]                r_uvld;

  // Decode each master's target bank and split requests per bank.
  always_comb begin
    w_bidx  = '0;
    w_waddr = '0;
    w_unmap = '0;
    w_breq  = '0;
    for (int m = 0; m < N_MST; m++) begin
      w_bidx[m]  = FW'(bank_idx(64'(m_addr[m]), BSEL_LSB));
      w_waddr[m] = BANK_AW'(bank_waddr(64'(m_addr[m]), BW));
      w_unmap[m] = m_req[m] && (w_bidx[m] >= FW'(N_BANK));
      for (int b = 0; b < N_BANK; b++)
        w_breq[b][m] = m_req[m] && (w_bidx[m] == FW'(b));
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    rr_arb #(.N(N_MST), .RR_EN(RR_EN)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_breq[b]),
      .i_en  (!b_busy[b] && !rst),
      .o_gnt (w_bgnt[b])
    );
  end

  // Bank command mux from the one-hot winner; idle banks drive zeros.
  always_comb begin
    b_cs   = '0;
    b_we   = '0;
    b_addr = '0;
    b_byte = '0;
    b_di   = '0;
    w_own  = '0;
    for (int b = 0; b < N_BANK; b++) begin
      b_cs[b] = |w_bgnt[b];
      for (int m = 0; m < N_MST; m++) begin
        if (w_bgnt[b][m]) begin
          b_we[b]   = m_we[m];
          b_addr[b] = w_waddr[m];
          b_byte[b] = m_byte[m];
          b_di[b]   = m_wdata[m];
          w_own[b]  = OWN_W'(m);
        end
      end
    end
  end

  // Unmapped requests are accepted immediately; banks add their winners.
  always_comb begin
    m_gnt = w_unmap & {N_MST{!rst}};
    for (int b = 0; b < N_BANK; b++) m_gnt = m_gnt | w_bgnt[b];
  end

  // Capture who owns each bank's response and which masters hit unmapped space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp  <= '0;
      r_uvld <= '0;
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        r_rsp[b].vld   <= b_cs[b];
        r_rsp[b].we    <= b_we[b];
        r_rsp[b].err   <= 1'b0;
        r_rsp[b].owner <= w_own[b];
      end
      r_uvld <= w_unmap;
    end
  end

  // Route bank responses back to their owners; reads carry bank data.
  always_comb begin
    m_rvalid = r_uvld;
    m_err    = r_uvld;
    m_rdata  = '0;
    for (int b = 0; b < N_BANK; b++) begin
      for (int m = 0; m < N_MST; m++) begin
        if (r_rsp[b].vld && r_rsp[b].owner == OWN_W'(m)) begin
          m_rvalid[m] = 1'b1;
          m_err[m]    = m_err[m] | r_rsp[b].err;
          if (!r_rsp[b].we && !r_rsp[b].err) m_rdata[m] = m_rdata[m] | b_do[b];
        end
      end
    end
  end

  // A request, once raised, stays up with stable attributes until granted.
  for (genvar m = 0; m < N_MST; m++) begin : g_proto
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      m_req[m] && !m_gnt[m] |=> m_req[m] && $stable(m_addr[m]) && $stable(m_we[m]));
  end

endmodule

// File: tb/tb_sram_bank_arb.sv
// Scoreboard bench for sram_bank_arb: queued masters, bank memory model,
// reference arbitration model, plus directed scenario checks.
module tb_sram_bank_arb;

  localparam int NM = 4, NB = 2, AW = 32, DW = 32, BAW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]             m_req = '0, m_we = '0;
  logic [NM-1:0][AW-1:0]     m_addr = '0;
  logic [NM-1:0][DW/8-1:0]   m_byte = '0;
  logic [NM-1:0][DW-1:0]     m_wdata = '0;
  logic [NM-1:0]             m_gnt, m_rvalid, m_err;
  logic [NM-1:0][DW-1:0]     m_rdata;
  logic [NB-1:0]             b_cs, b_we;
  logic [NB-1:0][BAW-1:0]    b_addr;
  logic [NB-1:0][DW/8-1:0]   b_byte;
  logic [NB-1:0][DW-1:0]     b_di;
  logic [NB-1:0][DW-1:0]     b_do = '0;
  logic [NB-1:0]             b_busy = '0;

  // fixed-priority instance signals
  logic [NM-1:0]             f_req = '0, f_we = '0;
  logic [NM-1:0][AW-1:0]     f_addr = '0;
  logic [NM-1:0][DW/8-1:0]   f_byte = '0;
  logic [NM-1:0][DW-1:0]     f_wdata = '0;
  logic [NM-1:0]             f_gnt, f_rvalid, f_err;
  logic [NM-1:0][DW-1:0]     f_rdata;
  logic [NB-1:0]             f_cs, f_bwe;
  logic [NB-1:0][BAW-1:0]    f_baddr;
  logic [NB-1:0][DW/8-1:0]   f_bbyte;
  logic [NB-1:0][DW-1:0]     f_di;
  logic [NB-1:0]             f_busy = '0;

  sram_bank_arb dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_byte(m_byte),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_byte(b_byte), .b_di(b_di),
    .b_do(b_do), .b_busy(b_busy));

  sram_bank_arb #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .m_req(f_req), .m_we(f_we), .m_addr(f_addr), .m_byte(f_byte),
    .m_wdata(f_wdata), .m_gnt(f_gnt), .m_rvalid(f_rvalid), .m_rdata(f_rdata), .m_err(f_err),
    .b_cs(f_cs), .b_we(f_bwe), .b_addr(f_baddr), .b_byte(f_bbyte), .b_di(f_di),
    .b_do(b_do), .b_busy(f_busy));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } op_t;
  typedef struct { int m; logic [31:0] d; logic e; } ex_t;

  op_t           op_q [NM][$];
  ex_t           exp_q[$];
  int            ptr [NB];
  logic [NM-1:0] obs_gnt = '0;
  logic [31:0]   mem [NB][256];

  task automatic push(input int m, input logic we, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    op_t o;
    o.we = we; o.addr = a; o.be = be; o.wd = wd;
    op_q[m].push_back(o);
  endtask

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic flush();
    for (int m = 0; m < NM; m++) op_q[m].delete();
    exp_q.delete();
    m_req   = '0;
    obs_gnt = '0;
    for (int b = 0; b < NB; b++) ptr[b] = 0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50; c++) begin
      if (op_q[0].size() == 0 && op_q[1].size() == 0 && op_q[2].size() == 0 &&
          op_q[3].size() == 0 && exp_q.size() == 0) return;
      nxt();
    end
    chk("idle timeout", 64'd0, 64'd1);
  endtask

  // Bank memory model: read data appears the cycle after chip select.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (b_cs[b]) begin
        if (b_we[b]) begin
          for (int k = 0; k < 4; k++)
            if (b_byte[b][k]) mem[b][b_addr[b][7:0]][8*k +: 8] <= b_di[b][8*k +: 8];
        end else begin
          b_do[b] <= mem[b][b_addr[b][7:0]];
        end
      end
    end
  end

  // Master driver: retire the op granted last cycle, present the next.
  always @(posedge clk) begin
    #1;
    for (int m = 0; m < NM; m++) begin
      if (obs_gnt[m] && op_q[m].size() > 0) void'(op_q[m].pop_front());
      if (op_q[m].size() > 0) begin
        m_req[m]   = 1'b1;
        m_we[m]    = op_q[m][0].we;
        m_addr[m]  = op_q[m][0].addr;
        m_byte[m]  = op_q[m][0].be;
        m_wdata[m] = op_q[m][0].wd;
      end else begin
        m_req[m] = 1'b0;
      end
    end
  end

  // Monitor: check last cycle's responses, model this cycle's grants.
  logic [NM-1:0] eg, ev;
  logic [NB-1:0] ecs;
  int            win [NB];
  int            mk, bk;
  ex_t           r;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst gnt", 64'(m_gnt), 64'd0);
      chk("rst rvalid", 64'(m_rvalid), 64'd0);
      chk("rst cs", 64'(b_cs), 64'd0);
      chk("rst rdata", 64'(|m_rdata), 64'd0);
      obs_gnt = '0;
    end else begin
      ev = '0;
      while (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        ev[r.m] = 1'b1;
        chk("rdata", 64'(m_rdata[r.m]), 64'(r.d));
        chk("err", 64'(m_err[r.m]), 64'(r.e));
      end
      chk("rvalid", 64'(m_rvalid), 64'(ev));
      eg = '0; ecs = '0;
      for (int m = 0; m < NM; m++)
        if (m_req[m] && (m_addr[m] >> 16) >= NB) eg[m] = 1'b1;
      for (int b = 0; b < NB; b++) begin
        win[b] = -1;
        if (!b_busy[b])
          for (int i = 0; i < NM; i++) begin
            mk = (ptr[b] + i) % NM;
            if (win[b] < 0 && m_req[mk] && (m_addr[mk] >> 16) == b) win[b] = mk;
          end
        if (win[b] >= 0) begin
          eg[win[b]] = 1'b1;
          ecs[b]     = 1'b1;
          ptr[b]     = (win[b] + 1) % NM;
        end
      end
      chk("gnt", 64'(m_gnt), 64'(eg));
      chk("cs", 64'(b_cs), 64'(ecs));
      for (int b = 0; b < NB; b++) begin
        if (ecs[b]) begin
          mk = win[b];
          chk("b_we", 64'(b_we[b]), 64'(m_we[mk]));
          chk("b_addr", 64'(b_addr[b]), 64'(m_addr[mk][15:2]));
          chk("b_byte", 64'(b_byte[b]), 64'(m_byte[mk]));
          chk("b_di", 64'(b_di[b]), 64'(m_wdata[mk]));
        end
      end
      for (int m = 0; m < NM; m++) begin
        if (eg[m]) begin
          bk = int'(m_addr[m] >> 16);
          r.m = m;
          if (bk >= NB)     begin r.d = '0; r.e = 1'b1; end
          else if (m_we[m]) begin r.d = '0; r.e = 1'b0; end
          else              begin r.d = mem[bk][m_addr[m][9:2]]; r.e = 1'b0; end
          exp_q.push_back(r);
        end
      end
      obs_gnt = m_gnt;
    end
  end

  logic [NM-1:0] fg;

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++) mem[b][a] = 32'hC000_0000 | (b << 16) | a;
    mem[0][4] = 32'hDEAD_BEEF;
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;

    // all masters contend for bank0: RR rotates, fixed priority keeps M0
    for (int m = 0; m < NM; m++) begin
      push(m, 1'b0, 32'h100 + 16*m, 4'h0, 32'h0);
      push(m, 1'b0, 32'h104 + 16*m, 4'h0, 32'h0);
    end
    @(posedge clk); #2 f_req = '1;
    for (int c = 0; c < 8; c++) begin
      nxt();
      chk("rr seq", 64'(m_gnt), 64'(1) << (c % 4));
      chk("fp gnt", 64'(f_gnt), 64'h1);
    end
    fg = f_gnt;
    for (int c = 0; c < 8 && f_req != '0; c++) begin
      @(posedge clk); #2 f_req = f_req & ~fg;
      nxt();
      fg = f_gnt;
    end
    chk("fp drain", 64'(f_req), 64'd0);
    wait_idle();

    // single read, bank data returned next cycle
    push(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    @(posedge clk); #2;
    nxt();
    chk("t1 gnt", 64'(m_gnt), 64'h1);
    chk("t1 b_addr", 64'(b_addr[0]), 64'd4);
    chk("t1 cs", 64'(b_cs), 64'h1);
    nxt();
    chk("t1 rvalid", 64'(m_rvalid), 64'h1);
    chk("t1 rdata", 64'(m_rdata[0]), 64'hDEAD_BEEF);
    wait_idle();

    // two banks served in parallel
    push(0, 1'b0, 32'h0000_0040, 4'h0, 32'h0);
    push(1, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
    @(posedge clk); #2;
    nxt();
    chk("t3 gnt", 64'(m_gnt), 64'h3);
    chk("t3 cs", 64'(b_cs), 64'h3);
    nxt();
    chk("t3 rvalid", 64'(m_rvalid), 64'h3);
    chk("t3 rdata0", 64'(m_rdata[0]), 64'hC000_0010);
    chk("t3 rdata1", 64'(m_rdata[1]), 64'hC001_0000);
    wait_idle();

    // bank0 busy three cycles; pointer must not move while stalled
    b_busy = 2'b01;
    push(0, 1'b0, 32'h0000_0044, 4'h0, 32'h0);
    push(2, 1'b0, 32'h0000_0048, 4'h0, 32'h0);
    @(posedge clk); #2;
    for (int c = 0; c < 3; c++) begin
      nxt();
      chk("t4 busy gnt", 64'(m_gnt), 64'd0);
      chk("t4 busy cs", 64'(b_cs[0]), 64'd0);
    end
    @(posedge clk); #2 b_busy = '0;
    nxt();
    chk("t4 gnt m2", 64'(m_gnt), 64'h4);
    nxt();
    chk("t4 gnt m0", 64'(m_gnt), 64'h1);
    wait_idle();

    // partial write, then read back the merged word
    push(1, 1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678);
    @(posedge clk); #2;
    nxt();
    chk("t5 gnt", 64'(m_gnt), 64'h2);
    chk("t5 b_we", 64'(b_we), 64'h1);
    chk("t5 b_byte", 64'(b_byte[0]), 64'h3);
    chk("t5 b_di", 64'(b_di[0]), 64'h1234_5678);
    nxt();
    chk("t5 rvalid", 64'(m_rvalid), 64'h2);
    chk("t5 rdata", 64'(m_rdata[1]), 64'd0);
    wait_idle();
    push(1, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
    @(posedge clk); #2;
    nxt(); nxt();
    chk("t5 readback", 64'(m_rdata[1]), 64'hC000_5678);
    wait_idle();

    // unmapped bank: immediate grant, error response, no bank activity
    push(3, 1'b0, 32'h0002_0000, 4'h0, 32'h0);
    @(posedge clk); #2;
    nxt();
    chk("t6 gnt", 64'(m_gnt), 64'h8);
    chk("t6 cs", 64'(b_cs), 64'd0);
    nxt();
    chk("t6 rvalid", 64'(m_rvalid), 64'h8);
    chk("t6 err", 64'(m_err), 64'h8);
    chk("t6 rdata", 64'(m_rdata[3]), 64'd0);
    wait_idle();

    // reset right after the grant drops the pending response
    push(3, 1'b0, 32'h0002_0000, 4'h0, 32'h0);
    @(posedge clk); #2;
    nxt();
    chk("t6b gnt", 64'(m_gnt), 64'h8);
    rst = 1'b1;
    flush();
    nxt();
    chk("t6b no rvalid", 64'(m_rvalid), 64'd0);
    chk("t6b no err", 64'(m_err), 64'd0);
    @(posedge clk); #2 rst = 1'b0;

    // pointers restart at 0 after reset
    push(1, 1'b0, 32'h0000_004C, 4'h0, 32'h0);
    push(0, 1'b0, 32'h0000_0050, 4'h0, 32'h0);
    @(posedge clk); #2;
    nxt();
    chk("ptr reset", 64'(m_gnt), 64'h1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
